// File: rtl/branch_target_buffer_pkg.sv
// rtl/branch_target_buffer_pkg.sv - shared constants and types for the branch target buffer
package branch_target_buffer_pkg;

    localparam int BTB_ENTRIES_DEF = 16;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

endpackage

// File: rtl/branch_target_buffer_if.sv
// rtl/branch_target_buffer_if.sv - fetch lookup and EXE update bundle for the branch target buffer
interface branch_target_buffer_if;

    logic [31:0] PC_IF;
    logic        take_pre;
    logic [31:0] Pre_Target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        btb_clear;

    modport master (
        output PC_IF, upd_valid, upd_pc, upd_taken, upd_target, btb_clear,
        input  take_pre, Pre_Target
    );

    modport slave (
        input  PC_IF, upd_valid, upd_pc, upd_taken, upd_target, btb_clear,
        output take_pre, Pre_Target
    );

endinterface

// File: rtl/branch_target_buffer_sat_counter2.sv
// rtl/branch_target_buffer_sat_counter2.sv - 2-bit saturating direction counter, next-value logic
module sat_counter2
    import branch_target_buffer_pkg::*;
(
    input  ctr_t cur,
    input  logic en,
    input  logic inc,
    output ctr_t nxt
);

    always_comb begin
        nxt = cur;
        if (en) begin
            if (inc) begin
                if (cur != ST) nxt = cur + 2'd1;
            end else begin
                if (cur != SNT) nxt = cur - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with combinational lookup and single-cycle update
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEF,
    parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   resetn,
    branch_target_buffer_if.slave  bus
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [29:0]            target_q [BTB_ENTRIES];
    ctr_t                   ctr_q    [BTB_ENTRIES];
    ctr_t                   ctr_nxt  [BTB_ENTRIES];
    logic [BTB_ENTRIES-1:0] ctr_en;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             do_upd;
    logic             do_alloc;
    logic             do_train;

    logic unused_low_bits;
    assign unused_low_bits = ^{bus.PC_IF[1:0], bus.upd_pc[1:0], bus.upd_target[1:0]};

    // Lookup reads the arrays directly, so a same-cycle update is not visible until the next cycle.
    assign lk_idx = bus.PC_IF[IDX_W+1:2];
    assign lk_tag = bus.PC_IF[31:IDX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    always_comb begin
        bus.take_pre   = 1'b0;
        bus.Pre_Target = 32'h0;
        if (lk_hit) begin
            bus.take_pre   = ctr_q[lk_idx][1];
            bus.Pre_Target = {target_q[lk_idx], 2'b00};
        end
    end

    assign up_idx   = bus.upd_pc[IDX_W+1:2];
    assign up_tag   = bus.upd_pc[31:IDX_W+2];
    assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign do_upd   = bus.upd_valid && !bus.btb_clear;
    assign do_train = do_upd && up_hit;
    assign do_alloc = do_upd && !up_hit && bus.upd_taken;

    always_comb begin
        ctr_en = '0;
        if (do_train) ctr_en[up_idx] = 1'b1;
    end

    for (genvar i = 0; i < BTB_ENTRIES; i++) begin : g_ctr
        sat_counter2 u_ctr (
            .cur (ctr_q[i]),
            .en  (ctr_en[i]),
            .inc (bus.upd_taken),
            .nxt (ctr_nxt[i])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
        end else if (bus.btb_clear) begin
            valid_q <= '0;
        end else if (do_alloc) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; valid_q alone decides whether an entry is visible.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= bus.upd_target[31:2];
            ctr_q[up_idx]    <= WT;
        end else if (do_train) begin
            ctr_q[up_idx] <= ctr_nxt[up_idx];
            if (bus.upd_taken) target_q[up_idx] <= bus.upd_target[31:2];
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - directed vector bench for branch_target_buffer
module tb_branch_target_buffer;

    logic clk;
    logic resetn;

    branch_target_buffer_if bus ();

    branch_target_buffer #(.BTB_ENTRIES(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        upd_valid;
        logic [31:0] upd_pc;
        logic        upd_taken;
        logic [31:0] upd_target;
        logic        clear;
        logic [31:0] pc_if;
        logic        exp_take;
        logic [31:0] exp_target;
    } vec_t;

    vec_t vecs [$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic add(input string nm, input logic uv, input logic [31:0] up, input logic ut,
                       input logic [31:0] utg, input logic clr, input logic [31:0] pc,
                       input logic et, input logic [31:0] etg);
        vec_t v;
        v.name = nm; v.upd_valid = uv; v.upd_pc = up; v.upd_taken = ut; v.upd_target = utg;
        v.clear = clr; v.pc_if = pc; v.exp_take = et; v.exp_target = etg;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic et, input logic [31:0] etg);
        n_cmp++;
        if (bus.take_pre !== et || bus.Pre_Target !== etg) begin
            n_err++;
            $display("FAIL %s: got take_pre=%b Pre_Target=%h, want take_pre=%b Pre_Target=%h",
                     nm, bus.take_pre, bus.Pre_Target, et, etg);
        end
    endtask

    task automatic idle_inputs();
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = 32'h0;
        bus.upd_taken  = 1'b0;
        bus.upd_target = 32'h0;
        bus.btb_clear  = 1'b0;
    endtask

    initial begin
        // Expected values are the lookup seen before the vector's own update lands.
        add("reset_lookup",   0, 32'h0,        0, 32'h0,        0, 32'h1c000100, 0, 32'h0);
        add("alloc_same_cyc", 1, 32'h1c000100, 1, 32'h1c000200, 0, 32'h1c000100, 0, 32'h0);
        add("alloc_hit_wt",   0, 32'h0,        0, 32'h0,        0, 32'h1c000100, 1, 32'h1c000200);
        add("nt1_pre",        1, 32'h1c000100, 0, 32'h0,        0, 32'h1c000100, 1, 32'h1c000200);
        add("nt2_wnt",        1, 32'h1c000100, 0, 32'h0,        0, 32'h1c000100, 0, 32'h1c000200);
        add("t_from_snt",     1, 32'h1c000100, 1, 32'h1c000300, 0, 32'h1c000100, 0, 32'h1c000200);
        add("wnt_newtgt",     0, 32'h0,        0, 32'h0,        0, 32'h1c000100, 0, 32'h1c000300);
        add("t_from_wnt",     1, 32'h1c000100, 1, 32'h1c000300, 0, 32'h1c000100, 0, 32'h1c000300);
        add("wt_again",       1, 32'h1c000100, 1, 32'h1c000300, 0, 32'h1c000100, 1, 32'h1c000300);
        add("st_sat_inc",     1, 32'h1c000100, 1, 32'h1c000300, 0, 32'h1c000100, 1, 32'h1c000300);
        add("st_nt",          1, 32'h1c000100, 0, 32'h0,        0, 32'h1c000100, 1, 32'h1c000300);
        add("wt_nt",          1, 32'h1c000100, 0, 32'h0,        0, 32'h1c000100, 1, 32'h1c000300);
        add("wnt_after_sat",  0, 32'h0,        0, 32'h0,        0, 32'h1c000100, 0, 32'h1c000300);
        add("alias_upd",      1, 32'h1c000140, 1, 32'h1c000500, 0, 32'h1c000100, 0, 32'h1c000300);
        add("alias_old_miss", 0, 32'h0,        0, 32'h0,        0, 32'h1c000100, 0, 32'h0);
        add("alias_new_hit",  0, 32'h0,        0, 32'h0,        0, 32'h1c000140, 1, 32'h1c000500);
        add("miss_nt_upd",    1, 32'h1c000180, 0, 32'h1c000700, 0, 32'h1c000140, 1, 32'h1c000500);
        add("miss_nt_keep",   0, 32'h0,        0, 32'h0,        0, 32'h1c000140, 1, 32'h1c000500);
        add("miss_nt_noaloc", 0, 32'h0,        0, 32'h0,        0, 32'h1c000180, 0, 32'h0);
        add("other_idx_upd",  1, 32'h1c000104, 1, 32'h1c000800, 0, 32'h1c000140, 1, 32'h1c000500);
        add("other_idx_hit",  0, 32'h0,        0, 32'h0,        0, 32'h1c000104, 1, 32'h1c000800);
        add("bypass_old",     1, 32'h1c000104, 1, 32'h1c000900, 0, 32'h1c000104, 1, 32'h1c000800);
        add("bypass_new",     0, 32'h0,        0, 32'h0,        0, 32'h1c000104, 1, 32'h1c000900);
        add("clear_w_upd",    1, 32'h1c000108, 1, 32'h1c000a00, 1, 32'h1c000104, 1, 32'h1c000900);
        add("clear_miss_104", 0, 32'h0,        0, 32'h0,        0, 32'h1c000104, 0, 32'h0);
        add("clear_drop_108", 0, 32'h0,        0, 32'h0,        0, 32'h1c000108, 0, 32'h0);
        add("clear_miss_140", 0, 32'h0,        0, 32'h0,        0, 32'h1c000140, 0, 32'h0);
        add("lowbits_upd",    1, 32'h1c000113, 1, 32'h1c000b03, 0, 32'h1c000110, 0, 32'h0);
        add("lowbits_hit",    0, 32'h0,        0, 32'h0,        0, 32'h1c000112, 1, 32'h1c000b00);

        idle_inputs();
        bus.PC_IF = 32'h1c000100;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            bus.upd_valid  = vecs[i].upd_valid;
            bus.upd_pc     = vecs[i].upd_pc;
            bus.upd_taken  = vecs[i].upd_taken;
            bus.upd_target = vecs[i].upd_target;
            bus.btb_clear  = vecs[i].clear;
            bus.PC_IF      = vecs[i].pc_if;
            #1;
            check(vecs[i].name, vecs[i].exp_take, vecs[i].exp_target);
            @(posedge clk);
        end

        // Mid-run asynchronous reset: lookup must drop without waiting for a clock edge.
        @(negedge clk);
        idle_inputs();
        bus.PC_IF = 32'h1c000110;
        #1;
        check("pre_async_rst", 1'b1, 32'h1c000b00);
        #1;
        resetn = 1'b0;
        #1;
        check("async_rst_now", 1'b0, 32'h0);

        // Update presented in the cycle reset releases is kept.
        @(negedge clk);
        resetn         = 1'b1;
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h1c000100;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h1c000c00;
        bus.PC_IF      = 32'h1c000100;
        #1;
        check("rst_rel_pre", 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        check("rst_rel_upd", 1'b1, 32'h1c000c00);
        bus.PC_IF = 32'h1c000110;
        #1;
        check("rst_rel_old", 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 The parameter list SHALL be as follows, one per line: name, default, meaning.
- BTB_ENTRIES, 16: number of direct-mapped entries, power of two from 4 to 64.
- IDX_W, log2(BTB_ENTRIES): index width.
REQ-002 The port list SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1: single clock, rising edge.
- resetn: in, 1, asynchronous active-low reset.
- PC_IF, in, 32: fetch PC to look up.
- take_pre, out, 1: prediction taken for PC_IF.
- Pre_Target, out, 32: predicted target for PC_IF.
- upd_valid, in, 1: a resolved branch/jump from EXE is presented this cycle.
- upd_pc, in, 32: PC of the resolved instruction.
- upd_taken, in, 1: resolved direction.
- upd_target, in, 32: resolved target.
- btb_clear, in, 1: invalidate all entries.

Function
REQ-003 Each entry SHALL hold: valid (1 bit), tag = PC[31:IDX_W+2], target[31:2], and a 2-bit saturating counter.
REQ-004 The lookup SHALL be purely combinational within the same cycle: index = PC_IF[IDX_W+1:2]; hit = valid & (tag == PC_IF[31:IDX_W+2]).
REQ-005 take_pre SHALL equal hit & ctr[1]; Pre_Target SHALL be {target,2'b00} on hit, otherwise 32'h0.
REQ-006 When take_pre=0, Pre_Target SHALL be don't-care for the consumer, but it SHALL still follow REQ-005.
REQ-007 Updates SHALL be written at the rising edge that ends the cycle in which upd_valid=1; the write occurs in exactly one cycle.
REQ-008 On an update hit with upd_taken=1: ctr SHALL increment, saturating at 2'b11, and the target SHALL be overwritten with upd_target[31:2].
REQ-009 On an update hit with upd_taken=0: ctr SHALL decrement, saturating at 2'b00; the entry SHALL remain valid.
REQ-010 On an update miss (invalid, or tag mismatch) with upd_taken=1: the entry SHALL be allocated or replaced (valid=1, new tag, target, ctr=2'b10).
REQ-011 On an update miss with upd_taken=0: there SHALL be no state change.
REQ-012 If a lookup and an update hit the same index in the same cycle, the lookup SHALL return pre-update contents; there is no bypass.
REQ-013 btb_clear=1 SHALL clear all valid bits at the next edge; targets and counters need not be cleared.
REQ-014 If btb_clear and upd_valid are asserted in the same cycle, clear SHALL win and the update SHALL be dropped.
REQ-015 Updates SHALL be independent of pipeline stall; the EXE stage presents each resolved instruction exactly once.
REQ-016 upd_pc[1:0] and upd_target[1:0] SHALL be ignored.

Reset
REQ-017 When resetn=0, all valid bits SHALL clear asynchronously, so that take_pre=0 and Pre_Target=32'h0 immediately.
REQ-018 Counter and target storage need not be reset.
REQ-019 Reset SHALL be released synchronously to clk by the top level.
REQ-020 An update presented in the cycle where reset deasserts SHALL be honoured.

Structure
REQ-021 The shared package SHALL define BTB_ENTRIES default and the counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
REQ-022 Each counter SHALL be implemented by one sub-module, sat_counter2: inputs en and inc, outputs the next value, saturating.
REQ-023 The valid bits SHALL use flops; tag, target and counter arrays may be flops or LUT-RAM with asynchronous read.

Verification
REQ-024 After reset with PC_IF=32'h1c000100, the bench SHALL check take_pre=0 and Pre_Target=0.
REQ-025 Update pc=32'h1c000100, taken=1, target=32'h1c000200; next cycle, lookup of the same PC SHALL give take_pre=1 and Pre_Target=32'h1c000200 (ctr=WT).
REQ-026 From WT, apply two not-taken updates to the same PC: take_pre SHALL be 0 after the first, and ctr SHALL be SNT after the second. Then apply one taken update: ctr SHALL be WNT and take_pre SHALL be 0.
REQ-027 Aliasing case: with 32'h1c000100 allocated, a taken update at 32'h1c000140 (same index for 16 entries) SHALL replace the entry, and the lookup of 32'h1c000100 SHALL then miss.
REQ-028 Same-cycle lookup and update to the same index SHALL return the old target; the new target SHALL appear the next cycle.
REQ-029 btb_clear together with upd_valid SHALL leave all lookups missing; resetn pulsed low mid-run SHALL force take_pre=0 within the same cycle.
